// File: rtl/ifft_radix4_bfly_pipe_if.sv
`default_nettype none
//==============================================================================
// Module : ifft_radix4_bfly_pipe_if
// Brief  : Handshake and data bundle for the inverse radix-4 butterfly pipeline.
// Rev    : 1.0 - initial release
//==============================================================================
interface ifft_radix4_bfly_pipe_if #(
    parameter int TAG_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [31:0]       ar, ai, br, bi, cr, ci, dr, di;
    logic signed [15:0]       w0r, w0i, w1r, w1i, w2r, w2i;
    logic                     scale_en;
    logic [TAG_W-1:0]         in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [31:0]       out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i;
    logic [TAG_W-1:0]         out_tag;
    logic                     busy;

    modport master (
        output in_valid, ar, ai, br, bi, cr, ci, dr, di,
               w0r, w0i, w1r, w1i, w2r, w2i, scale_en, in_tag, out_ready,
        input  in_ready, out_valid, out0r, out0i, out1r, out1i,
               out2r, out2i, out3r, out3i, out_tag, busy
    );

    modport slave (
        input  in_valid, ar, ai, br, bi, cr, ci, dr, di,
               w0r, w0i, w1r, w1i, w2r, w2i, scale_en, in_tag, out_ready,
        output in_ready, out_valid, out0r, out0i, out1r, out1i,
               out2r, out2i, out3r, out3i, out_tag, busy
    );
endinterface
`default_nettype wire

// File: rtl/ifft_radix4_bfly_pipe.sv
`default_nettype none
//==============================================================================
// Module : ifft_radix4_bfly_pipe
// Brief  : Three-stage inverse radix-4 butterfly (conjugated twiddles), with
//          optional divide-by-4 and a single global stall driven by out_ready.
// Rev    : 1.0 - initial release
//==============================================================================
module ifft_radix4_bfly_pipe #(
    parameter int TAG_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ifft_radix4_bfly_pipe_if.slave  bus
);

    // x * conj(w) in Q1.15; 48-bit product, bits [46:15] kept.
    function automatic logic signed [31:0] f_cmul_re(
        input logic signed [31:0] xr, xi,
        input logic signed [15:0] wr, wi
    );
        logic signed [47:0] xr_e, xi_e, wr_e, wi_e;
        xr_e = {{16{xr[31]}}, xr};
        xi_e = {{16{xi[31]}}, xi};
        wr_e = {{32{wr[15]}}, wr};
        wi_e = {{32{wi[15]}}, wi};
        return 32'((xr_e * wr_e + xi_e * wi_e) >>> 15);
    endfunction

    function automatic logic signed [31:0] f_cmul_im(
        input logic signed [31:0] xr, xi,
        input logic signed [15:0] wr, wi
    );
        logic signed [47:0] xr_e, xi_e, wr_e, wi_e;
        xr_e = {{16{xr[31]}}, xr};
        xi_e = {{16{xi[31]}}, xi};
        wr_e = {{32{wr[15]}}, wr};
        wi_e = {{32{wi[15]}}, wi};
        return 32'((xi_e * wr_e - xr_e * wi_e) >>> 15);
    endfunction

    logic signed [31:0] w_xr [4];
    logic signed [31:0] w_xi [4];
    logic signed [15:0] w_wr [3];
    logic signed [15:0] w_wi [3];
    logic               w_adv;

    logic               r_s1_vld, r_s2_vld, r_s3_vld;
    logic               r_s1_sc,  r_s2_sc;
    logic [TAG_W-1:0]   r_s1_tag, r_s2_tag, r_s3_tag;
    logic signed [31:0] r_s1_ar, r_s1_ai;
    logic signed [31:0] r_s1_mr [3];
    logic signed [31:0] r_s1_mi [3];
    logic signed [31:0] r_s2_tr [4];
    logic signed [31:0] r_s2_ti [4];
    logic signed [31:0] r_s3_yr [4];
    logic signed [31:0] r_s3_yi [4];

    logic signed [31:0] w_tr [4];
    logic signed [31:0] w_ti [4];
    logic signed [31:0] w_yr [4];
    logic signed [31:0] w_yi [4];
    logic signed [31:0] w_sr [4];
    logic signed [31:0] w_si [4];

    assign w_xr[0] = bus.ar;  assign w_xi[0] = bus.ai;
    assign w_xr[1] = bus.br;  assign w_xi[1] = bus.bi;
    assign w_xr[2] = bus.cr;  assign w_xi[2] = bus.ci;
    assign w_xr[3] = bus.dr;  assign w_xi[3] = bus.di;
    assign w_wr[0] = bus.w0r; assign w_wi[0] = bus.w0i;
    assign w_wr[1] = bus.w1r; assign w_wi[1] = bus.w1i;
    assign w_wr[2] = bus.w2r; assign w_wi[2] = bus.w2i;

    // The whole pipe moves as one; only a stalled output slot blocks it.
    assign w_adv        = !r_s3_vld || bus.out_ready;
    assign bus.in_ready = w_adv;

    // t0 = a+m1, t1 = a-m1, t2 = m0+m2, t3 = m0-m2
    assign w_tr[0] = r_s1_ar + r_s1_mr[1];
    assign w_ti[0] = r_s1_ai + r_s1_mi[1];
    assign w_tr[1] = r_s1_ar - r_s1_mr[1];
    assign w_ti[1] = r_s1_ai - r_s1_mi[1];
    assign w_tr[2] = r_s1_mr[0] + r_s1_mr[2];
    assign w_ti[2] = r_s1_mi[0] + r_s1_mi[2];
    assign w_tr[3] = r_s1_mr[0] - r_s1_mr[2];
    assign w_ti[3] = r_s1_mi[0] - r_s1_mi[2];

    // Inverse rotation: outputs 1 and 3 use +j / -j on t3.
    assign w_yr[0] = r_s2_tr[0] + r_s2_tr[2];
    assign w_yi[0] = r_s2_ti[0] + r_s2_ti[2];
    assign w_yr[1] = r_s2_tr[1] - r_s2_ti[3];
    assign w_yi[1] = r_s2_ti[1] + r_s2_tr[3];
    assign w_yr[2] = r_s2_tr[0] - r_s2_tr[2];
    assign w_yi[2] = r_s2_ti[0] - r_s2_ti[2];
    assign w_yr[3] = r_s2_tr[1] + r_s2_ti[3];
    assign w_yi[3] = r_s2_ti[1] - r_s2_tr[3];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_scale
            assign w_sr[g] = r_s2_sc ? (w_yr[g] >>> 2) : w_yr[g];
            assign w_si[g] = r_s2_sc ? (w_yi[g] >>> 2) : w_yi[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
            r_s1_sc  <= 1'b0;
            r_s2_sc  <= 1'b0;
            r_s1_tag <= '0;
            r_s2_tag <= '0;
            r_s3_tag <= '0;
            r_s1_ar  <= '0;
            r_s1_ai  <= '0;
            r_s1_mr  <= '{default: '0};
            r_s1_mi  <= '{default: '0};
            r_s2_tr  <= '{default: '0};
            r_s2_ti  <= '{default: '0};
            r_s3_yr  <= '{default: '0};
            r_s3_yi  <= '{default: '0};
        end else if (w_adv) begin
            r_s1_vld <= bus.in_valid;
            r_s1_sc  <= bus.scale_en;
            r_s1_tag <= bus.in_tag;
            r_s1_ar  <= w_xr[0];
            r_s1_ai  <= w_xi[0];
            for (int k = 0; k < 3; k++) begin
                r_s1_mr[k] <= f_cmul_re(w_xr[k+1], w_xi[k+1], w_wr[k], w_wi[k]);
                r_s1_mi[k] <= f_cmul_im(w_xr[k+1], w_xi[k+1], w_wr[k], w_wi[k]);
            end
            r_s2_vld <= r_s1_vld;
            r_s2_sc  <= r_s1_sc;
            r_s2_tag <= r_s1_tag;
            r_s2_tr  <= w_tr;
            r_s2_ti  <= w_ti;
            r_s3_vld <= r_s2_vld;
            r_s3_tag <= r_s2_tag;
            r_s3_yr  <= w_sr;
            r_s3_yi  <= w_si;
        end
    end

    assign bus.out_valid = r_s3_vld;
    assign bus.out_tag   = r_s3_tag;
    assign bus.busy      = r_s1_vld | r_s2_vld | r_s3_vld;
    assign bus.out0r     = r_s3_yr[0];
    assign bus.out0i     = r_s3_yi[0];
    assign bus.out1r     = r_s3_yr[1];
    assign bus.out1i     = r_s3_yi[1];
    assign bus.out2r     = r_s3_yr[2];
    assign bus.out2i     = r_s3_yi[2];
    assign bus.out3r     = r_s3_yr[3];
    assign bus.out3i     = r_s3_yi[3];

endmodule
`default_nettype wire

// File: tb/tb_ifft_radix4_bfly_pipe.sv
`default_nettype none
//==============================================================================
// Module : tb_ifft_radix4_bfly_pipe
// Brief  : Vector table plus scoreboard bench for the inverse radix-4 butterfly.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_ifft_radix4_bfly_pipe;

    typedef struct packed {
        logic [3:0][31:0] xr;
        logic [3:0][31:0] xi;
        logic [2:0][15:0] wr;
        logic [2:0][15:0] wi;
        logic             sc;
        logic [7:0]       tag;
    } vin_t;

    typedef struct packed {
        logic [3:0][31:0] yr;
        logic [3:0][31:0] yi;
        logic [7:0]       tag;
    } vout_t;

    typedef struct packed {
        vin_t  v;
        vout_t e;
    } rec_t;

    localparam int c_NTBL = 20;

    logic  clk = 1'b0;
    logic  rst_n;
    int    n_vec = 0;
    int    n_err = 0;
    vout_t sb[$];
    rec_t  tbl [c_NTBL];

    ifft_radix4_bfly_pipe_if #(.TAG_W(8)) ifc ();

    ifft_radix4_bfly_pipe #(.TAG_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference: 64-bit products, 32-bit wrapping int sums.
    function automatic vout_t model(input vin_t v);
        int     mr[3], mi[3], yr[4], yi[4];
        int     ar, ai, t0r, t0i, t1r, t1i, t2r, t2i, t3r, t3i;
        longint p;
        vout_t  e;
        for (int k = 0; k < 3; k++) begin
            p = longint'($signed(v.xr[k+1])) * longint'($signed(v.wr[k]))
              + longint'($signed(v.xi[k+1])) * longint'($signed(v.wi[k]));
            mr[k] = int'(p >>> 15);
            p = longint'($signed(v.xi[k+1])) * longint'($signed(v.wr[k]))
              - longint'($signed(v.xr[k+1])) * longint'($signed(v.wi[k]));
            mi[k] = int'(p >>> 15);
        end
        ar  = $signed(v.xr[0]);  ai  = $signed(v.xi[0]);
        t0r = ar + mr[1];        t0i = ai + mi[1];
        t1r = ar - mr[1];        t1i = ai - mi[1];
        t2r = mr[0] + mr[2];     t2i = mi[0] + mi[2];
        t3r = mr[0] - mr[2];     t3i = mi[0] - mi[2];
        yr[0] = t0r + t2r;  yi[0] = t0i + t2i;
        yr[1] = t1r - t3i;  yi[1] = t1i + t3r;
        yr[2] = t0r - t2r;  yi[2] = t0i - t2i;
        yr[3] = t1r + t3i;  yi[3] = t1i - t3r;
        for (int k = 0; k < 4; k++) begin
            if (v.sc) begin
                yr[k] = yr[k] >>> 2;
                yi[k] = yi[k] >>> 2;
            end
            e.yr[k] = yr[k];
            e.yi[k] = yi[k];
        end
        e.tag = v.tag;
        return e;
    endfunction

    function automatic vin_t mkv(input int ar, ai, br, bi, cr, ci, dr, di,
                                 input int w0r, w0i, w1r, w1i, w2r, w2i,
                                 input bit sc, input int tg);
        vin_t v;
        v.xr[0] = ar; v.xi[0] = ai; v.xr[1] = br; v.xi[1] = bi;
        v.xr[2] = cr; v.xi[2] = ci; v.xr[3] = dr; v.xi[3] = di;
        v.wr[0] = 16'(w0r); v.wi[0] = 16'(w0i);
        v.wr[1] = 16'(w1r); v.wi[1] = 16'(w1i);
        v.wr[2] = 16'(w2r); v.wi[2] = 16'(w2i);
        v.sc  = sc;
        v.tag = 8'(tg);
        return v;
    endfunction

    function automatic vout_t mke(input int y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i,
                                  input int tg);
        vout_t e;
        e.yr[0] = y0r; e.yi[0] = y0i; e.yr[1] = y1r; e.yi[1] = y1i;
        e.yr[2] = y2r; e.yi[2] = y2i; e.yr[3] = y3r; e.yi[3] = y3i;
        e.tag = 8'(tg);
        return e;
    endfunction

    function automatic rec_t rnd_rec(input int tg);
        rec_t r;
        for (int k = 0; k < 4; k++) begin
            r.v.xr[k] = $urandom();
            r.v.xi[k] = $urandom();
        end
        for (int k = 0; k < 3; k++) begin
            r.v.wr[k] = 16'($urandom());
            r.v.wi[k] = 16'($urandom());
        end
        r.v.sc  = 1'($urandom_range(0, 1));
        r.v.tag = 8'(tg);
        r.e     = model(r.v);
        return r;
    endfunction

    function automatic vout_t grab();
        vout_t g;
        g.yr[0] = ifc.out0r; g.yi[0] = ifc.out0i;
        g.yr[1] = ifc.out1r; g.yi[1] = ifc.out1i;
        g.yr[2] = ifc.out2r; g.yi[2] = ifc.out2i;
        g.yr[3] = ifc.out3r; g.yi[3] = ifc.out3i;
        g.tag   = ifc.out_tag;
        return g;
    endfunction

    // Drives one vector, holds it until accepted, pushes its expectation.
    task automatic send(input rec_t r, output int stalls);
        bit acc = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.ar = r.v.xr[0]; ifc.ai = r.v.xi[0];
        ifc.br = r.v.xr[1]; ifc.bi = r.v.xi[1];
        ifc.cr = r.v.xr[2]; ifc.ci = r.v.xi[2];
        ifc.dr = r.v.xr[3]; ifc.di = r.v.xi[3];
        ifc.w0r = r.v.wr[0]; ifc.w0i = r.v.wi[0];
        ifc.w1r = r.v.wr[1]; ifc.w1i = r.v.wi[1];
        ifc.w2r = r.v.wr[2]; ifc.w2i = r.v.wi[2];
        ifc.scale_en = r.v.sc;
        ifc.in_tag   = r.v.tag;
        stalls = 0;
        while (!acc && stalls < 200) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                sb.push_back(r.e);
                acc = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got tag %0h expected no vector", ifc.out_tag);
            end else begin
                vout_t e, g;
                e = sb.pop_front();
                g = grab();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL out_vec tag %0h: got %h expected %h", e.tag, g, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int   st, tot, lat, seen;
        bit   done;
        rec_t bp [6];
        vout_t snap;

        // Hand-derived vectors, then random ones checked against the model.
        tbl[0].v = mkv(100,0, 0,0, 0,0, 0,0, 'h7FFF,0, 'h7FFF,0, 'h7FFF,0, 0, 'h11);
        tbl[0].e = mke(100,0, 100,0, 100,0, 100,0, 'h11);
        tbl[1].v = mkv(0,0, 200,0, 0,0, 0,0, 0,'h4000, 'h7FFF,0, 'h7FFF,0, 0, 'h22);
        tbl[1].e = mke(0,-100, 100,0, 0,100, -100,0, 'h22);
        tbl[2].v = mkv(400,0, 0,0, 0,0, 0,0, 'h7FFF,0, 'h7FFF,0, 'h7FFF,0, 1, 'h33);
        tbl[2].e = mke(100,0, 100,0, 100,0, 100,0, 'h33);
        tbl[3].v = mkv(-3,0, 0,0, 0,0, 0,0, 'h7FFF,0, 'h7FFF,0, 'h7FFF,0, 1, 'h44);
        tbl[3].e = mke(-1,0, -1,0, -1,0, -1,0, 'h44);
        tbl[4].v = mkv('h7FFFFFFF,0, 2,0, 0,0, 0,0, 'h4000,0, 0,0, 0,0, 0, 'h55);
        tbl[4].e = mke('h80000000,0, 'h7FFFFFFF,1, 'h7FFFFFFE,0, 'h7FFFFFFF,-1, 'h55);
        tbl[5].v = mkv(10,20, 0,0, 1000,-2000, 0,0, 0,0, 'h4000,0, 0,0, 0, 'h66);
        tbl[5].e = mke(510,-980, -490,1020, 510,-980, -490,1020, 'h66);
        tbl[6].v = mkv(0,0, 0,0, 0,0, 0,600, 0,0, 0,0, 'h4000,0, 0, 'h77);
        tbl[6].e = mke(0,300, 300,0, 0,-300, -300,0, 'h77);
        for (int i = 7; i < c_NTBL; i++) tbl[i] = rnd_rec(i);

        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        ifc.scale_en  = 1'b0;
        ifc.in_tag    = '0;
        {ifc.ar, ifc.ai, ifc.br, ifc.bi, ifc.cr, ifc.ci, ifc.dr, ifc.di} = '0;
        {ifc.w0r, ifc.w0i, ifc.w1r, ifc.w1i, ifc.w2r, ifc.w2i} = '0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'(0));
        chk("rst_busy",      64'(ifc.busy),      64'(0));
        chk("rst_in_ready",  64'(ifc.in_ready),  64'(1));
        chk("rst_out0r",     64'(ifc.out0r),     64'(0));
        chk("rst_out_tag",   64'(ifc.out_tag),   64'(0));

        // Impulse driven together with reset release: first edge accepts, latency 3.
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(tbl[0], st);
        ifc.in_valid = 1'b0;
        chk("first_edge_accept_stalls", 64'(st), 64'(0));
        chk("busy_after_accept", 64'(ifc.busy), 64'(1));
        lat = 1;
        forever begin
            @(negedge clk);
            if (ifc.out_valid || lat > 20) break;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(3));
        drain();

        // Table, back to back at full rate.
        tot = 0;
        for (int i = 1; i < c_NTBL; i++) begin
            send(tbl[i], st);
            tot += st;
        end
        ifc.in_valid = 1'b0;
        chk("throughput_stalls", 64'(tot), 64'(0));
        drain();

        // Backpressure: sink stalled for 5 cycles once the first result shows.
        for (int i = 0; i < 6; i++) bp[i] = rnd_rec('hA0 + i);
        ifc.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(bp[i], st);
                ifc.in_valid = 1'b0;
            end
            begin
                int w = 0;
                forever begin
                    @(negedge clk);
                    if (ifc.out_valid || w > 50) break;
                    w++;
                end
                snap = grab();
                for (int c = 0; c < 5; c++) begin
                    chk("stall_in_ready",  64'(ifc.in_ready),  64'(0));
                    chk("stall_out_valid", 64'(ifc.out_valid), 64'(1));
                    chk("stall_hold_tag",  64'(ifc.out_tag),   64'(snap.tag));
                    if (grab() !== snap) chk("stall_hold_data", 64'(1), 64'(0));
                    @(posedge clk); #1;
                    if (c < 4) @(negedge clk);
                end
                ifc.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two vectors in flight, one already at the output.
        send(rnd_rec('hC0), st);
        send(rnd_rec('hC1), st);
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_out_valid", 64'(ifc.out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(ifc.out_valid), 64'(0));
        chk("async_rst_busy",      64'(ifc.busy),      64'(0));
        chk("async_rst_in_ready",  64'(ifc.in_ready),  64'(1));
        chk("async_rst_out1r",     64'(ifc.out1r),     64'(0));
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ifc.out_valid || ifc.busy) seen++;
        end
        chk("no_stale_after_reset", 64'(seen), 64'(0));

        // Random sink backpressure over a longer stream.
        @(posedge clk); #1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) send(rnd_rec('h10 + i), st);
                ifc.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                int k = 0;
                while ((!done || sb.size() != 0) && k < 2000) begin
                    @(posedge clk); #1;
                    ifc.out_ready = ($urandom_range(0, 3) != 0);
                    k++;
                end
                ifc.out_ready = 1'b1;
            end
        join
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("final_busy", 64'(ifc.busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifft_radix4_bfly_pipe.md
IFFT_RADIX4_BFLY_PIPE -- requirements
Module: ifft_radix4_bfly_pipe

Interface
REQ-001 SHALL have parameter TAG_W, default 8: width of the sideband tag carried alongside each butterfly.
REQ-002 SHALL have one clock and asynchronous active-low reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have the input-side ports below.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts the vector this cycle.
- ar, ai, br, bi, cr, ci, dr, di  in  32 each  signed complex operands a, b, c, d.
- w0r, w0i, w1r, w1i, w2r, w2i  in  16 each  signed Q1.15 forward twiddles.
- scale_en  in  1  divide this butterfly's outputs by 4.
- in_tag  in  TAG_W  sideband tag.
REQ-004 SHALL have the output-side ports below.
- out_valid  out  1  output vector valid.
- out_ready  in  1  sink accepts the vector.
- out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i  out  32 each  signed results.
- out_tag  out  TAG_W  tag of the output vector.
- busy  out  1  any pipeline stage holds valid data.

Function
REQ-005 SHALL compute the inverse radix-4 butterfly by applying conjugated twiddles internally; callers supply the same forward twiddles used by the forward engine.
REQ-006 SHALL compute the products with 48-bit signed intermediates and keep bits [46:15]:
- m0 = b*conj(w0): m0r = br*w0r + bi*w0i; m0i = bi*w0r - br*w0i.
- m1 = c*conj(w1) and m2 = d*conj(w2), formed the same way.
REQ-007 SHALL form the partial sums: t0 = a+m1, t1 = a-m1, t2 = m0+m2, t3 = m0-m2.
REQ-008 SHALL form the outputs, all 32-bit two's-complement wrap-around with no saturation:
- out0 = t0+t2.
- out1r = t1r-t3i; out1i = t1i+t3r.
- out2 = t0-t2.
- out3r = t1r+t3i; out3i = t1i-t3r.
REQ-009 SHALL, when the scale_en value sampled with the vector is 1, arithmetic-shift every output right by 2 (floor); otherwise outputs are unshifted.
REQ-010 SHALL be a three-stage pipeline:
- S1 registers the products.
- S2 registers t0..t3.
- S3 registers the outputs after scaling.
- scale_en and in_tag travel with the data through all stages.
REQ-011 SHALL accept a vector when in_valid and in_ready are both 1; the vector is presented with out_valid=1 on the 3rd rising edge after acceptance when out_ready stays 1.
REQ-012 SHALL drive in_ready = (!out_valid) || out_ready; all stages advance together when in_ready=1 and hold when in_ready=0.
REQ-013 SHALL sustain throughput of one vector per cycle with out_ready=1.
REQ-014 SHALL carry empty slots (in_valid=0 on advance) as bubbles with stage valid=0; bubbles never raise out_valid.
REQ-015 SHALL keep out_valid and all outputs stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, on a cycle where out_valid and out_ready are both 1 and in_valid=1, retire the old vector and accept the new one in the same cycle, with no loss or duplication.
REQ-017 SHALL preserve input order at the output.
REQ-018 SHALL drive busy = OR of the S1, S2 and S3 valid bits.

Reset
REQ-019 SHALL, on rst_n=0, immediately clear all stage valid bits, out_valid and busy, and clear all data, tag and output registers to 0, independent of clk.
REQ-020 SHALL discard all in-flight vectors on a reset during operation; no stale vector appears after release.
REQ-021 SHALL drive in_ready=1 during and after reset, since out_valid=0.
REQ-022 SHALL accept a vector on the first rising edge after rst_n deasserts.

Verification
REQ-023 Impulse: a=100+0j, b=c=d=0, all w=(0x7FFF,0), scale_en=0 -> all four outputs 100+0j; out_valid exactly 3 cycles after acceptance.
REQ-024 Conjugation: b=200+0j, a=c=d=0, w0=(0,0x4000), scale_en=0 -> m0=-100j, giving:
- out0 = 0-100j.
- out1 = 100+0j.
- out2 = 0+100j.
- out3 = -100+0j.
REQ-025 Scaling: a=400, others 0, scale_en=1 -> all outputs 100; a=-3, scale_en=1 -> all outputs -1.
REQ-026 Backpressure: stream 6 vectors with out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 while stalled, outputs held stable, all 6 vectors emerge in order with matching tags.
REQ-027 Reset mid-flight: 2 vectors in the pipe, pull rst_n low for 1 cycle -> out_valid=0 and busy=0 immediately; no output appears after release until a new vector is accepted.
REQ-028 Wrap: a=0x7FFFFFFF, b=2, w0=(0x4000,0), c=d=0 -> out0r=0x80000000, no saturation.
